// File: rtl/cnt_counter_pkg.sv
// Shared widths, value types and reset constant for the counter core and its users.
package cnt_counter_pkg;

   localparam int unsigned CNT_W   = 32;
   localparam int unsigned PRESC_W = 8;

   typedef logic [CNT_W-1:0]   cnt_val_t;
   typedef logic [PRESC_W-1:0] presc_t;

   localparam cnt_val_t CNT_RST_VAL = '0;

endpackage : cnt_counter_pkg

// File: rtl/cnt_counter_if.sv
// Control/status bundle between the counter register wrapper (master) and the counter core (slave).
interface cnt_counter_if
   import cnt_counter_pkg::*;
#(
   parameter int unsigned CntWidth   = CNT_W,
   parameter int unsigned PrescWidth = PRESC_W
);

   logic                  cnt_en_i;
   logic                  cnt_clr_i;
   logic [CntWidth-1:0]   cnt_thr_i;
   logic [PrescWidth-1:0] presc_i;
   logic                  irq_en_i;
   logic [CntWidth-1:0]   cnt_val_o;
   logic                  cnt_tc_o;
   logic                  cnt_irq_o;

   modport master (
      output cnt_en_i, cnt_clr_i, cnt_thr_i, presc_i, irq_en_i,
      input  cnt_val_o, cnt_tc_o, cnt_irq_o
   );

   modport slave (
      input  cnt_en_i, cnt_clr_i, cnt_thr_i, presc_i, irq_en_i,
      output cnt_val_o, cnt_tc_o, cnt_irq_o
   );

endinterface : cnt_counter_if

// File: rtl/cnt_prescaler.sv
// Programmable prescaler: emits one tick every div_i+1 enabled cycles.
module cnt_prescaler
   import cnt_counter_pkg::*;
#(
   parameter int unsigned Width = PRESC_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [Width-1:0] div_i,
   output logic             tick_o
);

   logic [Width-1:0] p_q;
   logic [Width-1:0] p_d;
   logic             reached;

   // >= rather than == so that lowering div_i never forces a full wrap of p.
   assign reached = (p_q >= div_i);
   assign tick_o  = en_i & ~clr_i & reached;

   always_comb begin
      // NOTE: p_d takes a default first so every path assigns it and no latch is inferred.
      p_d = p_q;
      if (clr_i) begin
         p_d = '0;
      end else if (en_i) begin
         p_d = reached ? '0 : p_q + 1'b1;
      end
   end

   // NOTE: asynchronous active-low reset; state registers use non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

endmodule : cnt_prescaler

// File: rtl/cnt_counter_core.sv
// Prescaled wrap-at-threshold up-counter with terminal-count pulse and sticky interrupt.
module cnt_counter_core
   import cnt_counter_pkg::*;
#(
   parameter int unsigned CntWidth   = CNT_W,
   parameter int unsigned PrescWidth = PRESC_W
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   cnt_counter_if.slave  bus
);

   logic [CntWidth-1:0] cnt_val_q;
   logic                cnt_tc_q;
   logic                cnt_irq_q;
   logic                tick;
   logic                wrap;

   cnt_prescaler #(
      .Width (PrescWidth)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (bus.cnt_en_i),
      .clr_i  (bus.cnt_clr_i),
      .div_i  (bus.presc_i),
      .tick_o (tick)
   );

   // Wrap test precedes the increment, so the count never overflows and a lowered
   // threshold forces a wrap on the very next tick.
   assign wrap = tick & (cnt_val_q >= bus.cnt_thr_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_val_q <= CntWidth'(CNT_RST_VAL);
         cnt_tc_q  <= 1'b0;
         cnt_irq_q <= 1'b0;
      end else if (bus.cnt_clr_i) begin
         cnt_val_q <= CntWidth'(CNT_RST_VAL);
         cnt_tc_q  <= 1'b0;
         cnt_irq_q <= 1'b0;
      end else begin
         cnt_tc_q <= wrap;
         if (wrap) begin
            cnt_val_q <= '0;
         end else if (tick) begin
            cnt_val_q <= cnt_val_q + 1'b1;
         end
         if (wrap && bus.irq_en_i) begin
            cnt_irq_q <= 1'b1;
         end
      end
   end

   assign bus.cnt_val_o = cnt_val_q;
   assign bus.cnt_tc_o  = cnt_tc_q;
   assign bus.cnt_irq_o = cnt_irq_q;

endmodule : cnt_counter_core

// File: tb/tb_cnt_counter_core.sv
// Directed bench for cnt_counter_core: per-cycle model compare plus hand-computed checkpoints.
module tb_cnt_counter_core;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b1;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;

   cnt_counter_if #(.CntWidth(32), .PrescWidth(8)) bus ();

   cnt_counter_core #(.CntWidth(32), .PrescWidth(8)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tick every presc+1 enabled cycles, wrap to 0 once the count reaches thr.
   longint unsigned m_val = 0;
   int unsigned     m_p   = 0;
   bit              m_tc  = 0;
   bit              m_irq = 0;
   bit              m_tick;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni || bus.cnt_clr_i) begin
         m_val = 0; m_p = 0; m_tc = 0; m_irq = 0;
      end else begin
         m_tick = 0;
         m_tc   = 0;
         if (bus.cnt_en_i) begin
            if (m_p >= int'(bus.presc_i)) begin
               m_tick = 1;
               m_p    = 0;
            end else begin
               m_p = m_p + 1;
            end
         end
         if (m_tick) begin
            if (m_val >= longint'(bus.cnt_thr_i)) begin
               m_val = 0;
               m_tc  = 1;
               if (bus.irq_en_i) m_irq = 1;
            end else begin
               m_val = m_val + 1;
            end
         end
      end
   end

   always @(negedge clk_i) begin
      if (cmp_on) begin
         check("cmp_val", bus.cnt_val_o, 32'(m_val));
         check("cmp_tc",  {31'd0, bus.cnt_tc_o},  {31'd0, m_tc});
         check("cmp_irq", {31'd0, bus.cnt_irq_o}, {31'd0, m_irq});
      end
   end

   task automatic drive(input bit en, input bit clr, input int thr, input int presc, input bit irq_en);
      bus.cnt_en_i  = en;
      bus.cnt_clr_i = clr;
      bus.cnt_thr_i = 32'(thr);
      bus.presc_i   = 8'(presc);
      bus.irq_en_i  = irq_en;
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   int basic_val [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
   int presc_val [9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
   int sticky_val[5]  = '{1, 0, 1, 0, 1};

   initial begin
      drive(0, 0, 0, 0, 0);
      #1 rst_ni = 1'b0;
      cmp_on = 1'b1;
      #2;
      check("rst_val", bus.cnt_val_o, 0);
      check("rst_tc",  {31'd0, bus.cnt_tc_o},  0);
      check("rst_irq", {31'd0, bus.cnt_irq_o}, 0);
      cyc();
      #3 rst_ni = 1'b1;
      cyc();

      // Basic count and wrap
      drive(1, 0, 3, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("basic_val", bus.cnt_val_o, 32'(basic_val[i]));
         check("basic_tc", {31'd0, bus.cnt_tc_o}, (i == 3 || i == 7) ? 1 : 0);
      end

      // Prescaler divide by 3
      drive(0, 1, 10, 2, 0);
      cyc();
      check("clr_val", bus.cnt_val_o, 0);
      drive(1, 0, 10, 2, 0);
      for (int i = 0; i < 9; i++) begin
         cyc();
         check("presc_val", bus.cnt_val_o, 32'(presc_val[i]));
         check("presc_tc", {31'd0, bus.cnt_tc_o}, 0);
      end

      // Interrupt stickiness
      drive(0, 1, 1, 0, 1);
      cyc();
      drive(1, 0, 1, 0, 1);
      cyc();
      check("sticky_pre_irq", {31'd0, bus.cnt_irq_o}, 0);
      cyc();
      check("sticky_wrap_val", bus.cnt_val_o, 0);
      check("sticky_wrap_tc", {31'd0, bus.cnt_tc_o}, 1);
      check("sticky_set_irq", {31'd0, bus.cnt_irq_o}, 1);
      drive(1, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("sticky_val", bus.cnt_val_o, 32'(sticky_val[i]));
         check("sticky_hold_irq", {31'd0, bus.cnt_irq_o}, 1);
      end

      // Clear priority over enable with interrupt pending
      drive(1, 0, 10, 0, 0);
      repeat (4) cyc();
      check("pre_clr_val", bus.cnt_val_o, 5);
      drive(1, 1, 10, 0, 0);
      cyc();
      check("clr_prio_val", bus.cnt_val_o, 0);
      check("clr_prio_irq", {31'd0, bus.cnt_irq_o}, 0);
      check("clr_prio_tc",  {31'd0, bus.cnt_tc_o},  0);
      drive(1, 0, 10, 0, 0);
      cyc();
      check("clr_resume_val", bus.cnt_val_o, 1);

      // Threshold lowered below the current count
      repeat (7) cyc();
      check("pre_lower_val", bus.cnt_val_o, 8);
      drive(1, 0, 4, 0, 0);
      cyc();
      check("lower_wrap_val", bus.cnt_val_o, 0);
      check("lower_wrap_tc", {31'd0, bus.cnt_tc_o}, 1);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("lower_count_val", bus.cnt_val_o, 32'(i));
         check("lower_count_tc", {31'd0, bus.cnt_tc_o}, 0);
      end
      cyc();
      check("lower_rewrap_tc", {31'd0, bus.cnt_tc_o}, 1);

      // Threshold zero: stuck at 0 with terminal count high every cycle
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("thr0_val", bus.cnt_val_o, 0);
         check("thr0_tc", {31'd0, bus.cnt_tc_o}, 1);
      end

      // Asynchronous reset mid-count
      drive(0, 1, 100, 3, 1);
      cyc();
      drive(1, 0, 100, 3, 1);
      repeat (4) cyc();
      check("async_pre_val4", bus.cnt_val_o, 1);
      repeat (2) cyc();
      check("async_pre_val6", bus.cnt_val_o, 1);
      #3 rst_ni = 1'b0;
      #2;
      check("async_rst_val", bus.cnt_val_o, 0);
      check("async_rst_tc",  {31'd0, bus.cnt_tc_o},  0);
      check("async_rst_irq", {31'd0, bus.cnt_irq_o}, 0);
      #2 rst_ni = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("async_post_val", bus.cnt_val_o, (i == 4) ? 1 : 0);
      end

      @(negedge clk_i);
      #1 cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cnt_counter_core

// File: doc/cnt_counter_core.md
Name: cnt_counter_core

Overview:
- Hardware counter that consumes the control-register outputs (enable, clear, threshold) and returns the current count value and terminal-count indication to the register block.
- Contains a programmable prescaler, a wrap-at-threshold up-counter, a one-cycle terminal-count pulse and a sticky interrupt line.
- Sits directly downstream of the counter control register wrapper in the counter subsystem.

Parameters:
- CntWidth, 32, width of counter value and threshold.
- PrescWidth, 8, width of prescaler divide value.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- cnt_en_i  input  1  count enable, level.
- cnt_clr_i  input  1  synchronous clear, level.
- cnt_thr_i  input  CntWidth  wrap threshold, inclusive.
- presc_i  input  PrescWidth  prescaler divide-minus-one; 0 means tick every enabled cycle.
- irq_en_i  input  1  interrupt enable.
- cnt_val_o  output  CntWidth  current count, registered.
- cnt_tc_o  output  1  terminal-count pulse, registered, one cycle.
- cnt_irq_o  output  1  sticky interrupt, registered.

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous, active-low.
- Reset values: cnt_val_o=0, cnt_tc_o=0, cnt_irq_o=0, prescaler count=0.
- Prescaler:
  - Internal counter p, PrescWidth bits.
  - While cnt_en_i=1 and no clear: if p>=presc_i, assert tick for that cycle and set p<=0; otherwise p<=p+1.
  - While cnt_en_i=0: p holds and no tick is generated.
  - Using >= means a reduced presc_i takes effect without a long wrap.
- Counter update on the clock edge at the end of a tick cycle:
  - If cnt_val_o >= cnt_thr_i: cnt_val_o<=0 (wrap).
  - Otherwise: cnt_val_o<=cnt_val_o+1.
  - Using >= means a lowered threshold forces a wrap on the next tick, with no 2^CntWidth run-out.
- Terminal count:
  - cnt_tc_o=1 for exactly the cycle after a wrap edge, else 0.
  - With cnt_thr_i=0 and presc_i=0 the counter stays at 0 and cnt_tc_o stays high continuously.
- Interrupt:
  - cnt_irq_o is set on a wrap when irq_en_i=1 and stays set until cleared.
  - Deasserting irq_en_i does not clear a pending cnt_irq_o.
- Clear (cnt_clr_i=1) has priority over everything:
  - Next edge: cnt_val_o<=0, p<=0, cnt_tc_o<=0, cnt_irq_o<=0.
  - No tick and no wrap in that cycle, even if cnt_en_i=1.
  - Clear held high keeps all state at 0.
- Latency: with presc_i=0, cnt_en_i rising at cycle n gives cnt_val_o=1 visible in cycle n+1, incrementing every cycle thereafter.
- Input changes mid-operation:
  - cnt_thr_i and presc_i are sampled every cycle, with no shadowing.
  - Changes take effect at the next tick or prescaler comparison.
- Arithmetic is unsigned. The increment never overflows, because the wrap condition precedes the increment.
- Asynchronous reset mid-count returns all state to reset values immediately. The first tick after release requires presc_i+1 enabled cycles.

Decomposition:
- Package cnt_counter_pkg holds:
  - CNT_W=32, PRESC_W=8 defaults.
  - Typedefs cnt_val_t and presc_t.
  - The documented reset constant CNT_RST_VAL=0.
- One sub-module, cnt_prescaler:
  - Inputs: clk_i, rst_ni, en_i, clr_i, div_i.
  - Output: tick_o.
  - Contains the p register and the >= compare.
- The wrap counter, tc pulse and irq flag live in cnt_counter_core.

Test Plan:
- Basic count and wrap:
  - Stimulus: reset, then thr=3, presc=0, en=1 for 10 cycles.
  - Response: cnt_val sequence 1,2,3,0,1,2,3,0,1,2. cnt_tc high only in the cycles where cnt_val=0 after a wrap.
- Prescaler divide:
  - Stimulus: thr=10, presc=2, en=1 for 9 cycles.
  - Response: cnt_val increments once every 3 cycles, reaching 3 after cycle 9. cnt_tc never asserts.
- Clear priority:
  - Stimulus: counting with cnt_val=5, then assert clr and en together for 1 cycle with irq pending.
  - Response: next cycle cnt_val=0 and cnt_irq=0. Counting resumes from 1 after clr drops, with presc=0.
- Threshold lowered below count:
  - Stimulus: cnt_val=8, change thr to 4, presc=0.
  - Response: next tick wraps to 0 with cnt_tc pulse, then counts 1..4.
- Interrupt stickiness:
  - Stimulus: irq_en=1, thr=1, presc=0, count through one wrap, then irq_en=0 for 5 cycles.
  - Response: cnt_irq goes high at the wrap and remains high until clr=1.
- Async reset mid-run:
  - Stimulus: thr=100, presc=3, pulse rst_ni low mid-count, not clock-aligned.
  - Response: all outputs 0 immediately. First increment 4 enabled cycles after release.
